mos6502_insn_assembler: RTL

Parametrised successor to the combinational opcode decoder. Accepts the raw fetch byte stream over a valid/ready handshake and decodes each opcode into mnemonic, addressing mode and length. It gathers 0–2 operand bytes and buffers complete instructions in a DEPTH-entry FIFO for the execute stage. Adds illegal-opcode detection, an optional trap mode, flush, and a saturating illegal-opcode counter.

---
 rtl/mos6502_pkg.sv | 49 ++++
 rtl/mos6502_opcode_rom.sv | 119 +++++++++++
 rtl/mos6502_insn_assembler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mos6502_pkg.sv
// Shared types for the 6502 instruction assembler.
//   mnem_e  : mnemonic codes, alphabetical (ADC=0 .. TYA=55)
//   mode_e  : addressing mode codes (IMP=0 .. REL=12)
//   state_e : byte-gathering FSM states
//   insn_t  : one assembled instruction as stored in the output FIFO
//   mode_len: addressing mode -> instruction length in bytes
package mos6502_pkg;

  typedef enum logic [5:0] {
    ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL,
    BRK, BVC, BVS, CLC, CLD, CLI, CLV, CMP, CPX, CPY,
    DEC, DEX, DEY, EOR, INC, INX, INY, JMP, JSR, LDA,
    LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL,
    ROR, RTI, RTS, SBC, SEC, SED, SEI, STA, STX, STY,
    TAX, TAY, TSX, TXA, TXS, TYA
  } mnem_e;

  typedef enum logic [3:0] {
    IMP, ACC, IMM, ZPG, ZPGX, ZPGY, ABS, ABSX, ABSY, IND, XIND, INDY, REL
  } mode_e;

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_OPER_LO,
    ST_OPER_HI
  } state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  mnem;
    logic [3:0]  mode;
    logic [1:0]  len;
    logic [15:0] operand;
    logic        illegal;
  } insn_t;

  // BRK is IMP and therefore one byte: its signature byte is left in the
  // stream and decodes as the next opcode.
  function automatic logic [1:0] mode_len(input logic [3:0] mode);
    logic [1:0] len;
    case (mode)
      IMP, ACC:             len = 2'd1;
      ABS, ABSX, ABSY, IND: len = 2'd3;
      default:              len = 2'd2;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mos6502_opcode_rom.sv
// Combinational 6502 opcode decoder.
//   opcode  : raw opcode byte
//   mnem    : mnemonic code (mnem_e)
//   mode    : addressing mode code (mode_e)
//   len     : instruction length 1..3
//   illegal : opcode is not one of the 151 official ones; reported as
//             a 1-byte NOP/IMP
module mos6502_opcode_rom
  import mos6502_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [5:0] mnem,
  output logic [3:0] mode,
  output logic [1:0] len,
  output logic       illegal
);

  // Column cc=01 is fully regular: aaa selects the ALU op, bbb the mode.
  function automatic logic [5:0] alu_mnem(input logic [2:0] aaa);
    logic [5:0] m;
    case (aaa)
      3'd0:    m = ORA;
      3'd1:    m = AND;
      3'd2:    m = EOR;
      3'd3:    m = ADC;
      3'd4:    m = STA;
      3'd5:    m = LDA;
      3'd6:    m = CMP;
      default: m = SBC;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] alu_mode(input logic [2:0] bbb);
    logic [3:0] m;
    case (bbb)
      3'd0:    m = XIND;
      3'd1:    m = ZPG;
      3'd2:    m = IMM;
      3'd3:    m = ABS;
      3'd4:    m = INDY;
      3'd5:    m = ZPGX;
      3'd6:    m = ABSY;
      default: m = ABSX;
    endcase
    return m;
  endfunction

  always_comb begin
    mnem    = NOP;
    mode    = IMP;
    illegal = 1'b0;
    case (opcode)
      8'h0A: {mnem, mode} = {ASL, ACC};   8'h06: {mnem, mode} = {ASL, ZPG};
      8'h16: {mnem, mode} = {ASL, ZPGX};  8'h0E: {mnem, mode} = {ASL, ABS};
      8'h1E: {mnem, mode} = {ASL, ABSX};
      8'h4A: {mnem, mode} = {LSR, ACC};   8'h46: {mnem, mode} = {LSR, ZPG};
      8'h56: {mnem, mode} = {LSR, ZPGX};  8'h4E: {mnem, mode} = {LSR, ABS};
      8'h5E: {mnem, mode} = {LSR, ABSX};
      8'h2A: {mnem, mode} = {ROL, ACC};   8'h26: {mnem, mode} = {ROL, ZPG};
      8'h36: {mnem, mode} = {ROL, ZPGX};  8'h2E: {mnem, mode} = {ROL, ABS};
      8'h3E: {mnem, mode} = {ROL, ABSX};
      8'h6A: {mnem, mode} = {ROR, ACC};   8'h66: {mnem, mode} = {ROR, ZPG};
      8'h76: {mnem, mode} = {ROR, ZPGX};  8'h6E: {mnem, mode} = {ROR, ABS};
      8'h7E: {mnem, mode} = {ROR, ABSX};
      8'hC6: {mnem, mode} = {DEC, ZPG};   8'hD6: {mnem, mode} = {DEC, ZPGX};
      8'hCE: {mnem, mode} = {DEC, ABS};   8'hDE: {mnem, mode} = {DEC, ABSX};
      8'hE6: {mnem, mode} = {INC, ZPG};   8'hF6: {mnem, mode} = {INC, ZPGX};
      8'hEE: {mnem, mode} = {INC, ABS};   8'hFE: {mnem, mode} = {INC, ABSX};
      8'h90: {mnem, mode} = {BCC, REL};   8'hB0: {mnem, mode} = {BCS, REL};
      8'hF0: {mnem, mode} = {BEQ, REL};   8'h30: {mnem, mode} = {BMI, REL};
      8'hD0: {mnem, mode} = {BNE, REL};   8'h10: {mnem, mode} = {BPL, REL};
      8'h50: {mnem, mode} = {BVC, REL};   8'h70: {mnem, mode} = {BVS, REL};
      8'h24: {mnem, mode} = {BIT, ZPG};   8'h2C: {mnem, mode} = {BIT, ABS};
      8'h00: {mnem, mode} = {BRK, IMP};
      8'h18: {mnem, mode} = {CLC, IMP};   8'hD8: {mnem, mode} = {CLD, IMP};
      8'h58: {mnem, mode} = {CLI, IMP};   8'hB8: {mnem, mode} = {CLV, IMP};
      8'hE0: {mnem, mode} = {CPX, IMM};   8'hE4: {mnem, mode} = {CPX, ZPG};
      8'hEC: {mnem, mode} = {CPX, ABS};
      8'hC0: {mnem, mode} = {CPY, IMM};   8'hC4: {mnem, mode} = {CPY, ZPG};
      8'hCC: {mnem, mode} = {CPY, ABS};
      8'hCA: {mnem, mode} = {DEX, IMP};   8'h88: {mnem, mode} = {DEY, IMP};
      8'hE8: {mnem, mode} = {INX, IMP};   8'hC8: {mnem, mode} = {INY, IMP};
      8'h4C: {mnem, mode} = {JMP, ABS};   8'h6C: {mnem, mode} = {JMP, IND};
      8'h20: {mnem, mode} = {JSR, ABS};
      8'hA2: {mnem, mode} = {LDX, IMM};   8'hA6: {mnem, mode} = {LDX, ZPG};
      8'hB6: {mnem, mode} = {LDX, ZPGY};  8'hAE: {mnem, mode} = {LDX, ABS};
      8'hBE: {mnem, mode} = {LDX, ABSY};
      8'hA0: {mnem, mode} = {LDY, IMM};   8'hA4: {mnem, mode} = {LDY, ZPG};
      8'hB4: {mnem, mode} = {LDY, ZPGX};  8'hAC: {mnem, mode} = {LDY, ABS};
      8'hBC: {mnem, mode} = {LDY, ABSX};
      8'hEA: {mnem, mode} = {NOP, IMP};
      8'h48: {mnem, mode} = {PHA, IMP};   8'h08: {mnem, mode} = {PHP, IMP};
      8'h68: {mnem, mode} = {PLA, IMP};   8'h28: {mnem, mode} = {PLP, IMP};
      8'h40: {mnem, mode} = {RTI, IMP};   8'h60: {mnem, mode} = {RTS, IMP};
      8'h38: {mnem, mode} = {SEC, IMP};   8'hF8: {mnem, mode} = {SED, IMP};
      8'h78: {mnem, mode} = {SEI, IMP};
      8'h86: {mnem, mode} = {STX, ZPG};   8'h96: {mnem, mode} = {STX, ZPGY};
      8'h8E: {mnem, mode} = {STX, ABS};
      8'h84: {mnem, mode} = {STY, ZPG};   8'h94: {mnem, mode} = {STY, ZPGX};
      8'h8C: {mnem, mode} = {STY, ABS};
      8'hAA: {mnem, mode} = {TAX, IMP};   8'hA8: {mnem, mode} = {TAY, IMP};
      8'hBA: {mnem, mode} = {TSX, IMP};   8'h8A: {mnem, mode} = {TXA, IMP};
      8'h9A: {mnem, mode} = {TXS, IMP};   8'h98: {mnem, mode} = {TYA, IMP};
      default: begin
        // 0x89 would be "STA #imm", which does not exist.
        if (opcode[1:0] == 2'b01 && opcode != 8'h89) begin
          mnem = alu_mnem(opcode[7:5]);
          mode = alu_mode(opcode[4:2]);
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

  assign len = mode_len(mode);

endmodule

// File: rtl/mos6502_insn_assembler.sv
// 6502 instruction assembler: byte stream in, whole instructions out.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : synchronous flush (drops partial insn and FIFO)
//   byte_i/_valid_i/_ready_o : fetch byte stream
//   insn_*_o, insn_ready_i   : FIFO head and pop handshake
//   trapped_o            : illegal opcode seen with TRAP_ILLEGAL=1
//   illegal_count_o      : saturating illegal-opcode count
//   fifo_level_o         : occupied FIFO entries
// Handshakes: a byte is taken on a cycle with byte_valid_i & byte_ready_o;
// the FIFO head is popped on a cycle with insn_valid_o & insn_ready_i.
// Neither ready depends combinationally on the other side's valid.
module mos6502_insn_assembler
  import mos6502_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 8,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [7:0]                 byte_i,
  input  logic                       byte_valid_i,
  output logic                       byte_ready_o,
  output logic                       insn_valid_o,
  input  logic                       insn_ready_i,
  output logic [7:0]                 insn_opcode_o,
  output logic [5:0]                 insn_mnem_o,
  output logic [3:0]                 insn_mode_o,
  output logic [1:0]                 insn_len_o,
  output logic [15:0]                insn_operand_o,
  output logic                       insn_illegal_o,
  output logic                       trapped_o,
  output logic [CNT_W-1:0]           illegal_count_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam bit TRAP_EN = (TRAP_ILLEGAL != 0);

  state_e             state_q, state_d;
  logic [5:0]         rom_mnem;
  logic [3:0]         rom_mode;
  logic [1:0]         rom_len;
  logic               rom_illegal;
  insn_t              hold_q;       // opcode + decode of the insn being gathered
  insn_t              push_entry;
  logic               push, pop, accept, byte_ready;
  logic               hold_load, lo_load;
  insn_t              mem [DEPTH];
  insn_t              head;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               trapped_q;
  logic [CNT_W-1:0]   cnt_q;

  mos6502_opcode_rom u_rom (
    .opcode  (byte_i),
    .mnem    (rom_mnem),
    .mode    (rom_mode),
    .len     (rom_len),
    .illegal (rom_illegal)
  );

  // Registered level only: a pop in the same cycle does not free a slot.
  assign byte_ready = rst_ni & ~flush_i & ~trapped_q & (level_q < LVL_W'(DEPTH));
  assign accept     = byte_valid_i & byte_ready;
  assign pop        = insn_ready_i & (level_q != '0) & ~flush_i;

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    hold_load  = 1'b0;
    lo_load    = 1'b0;
    case (state_q)
      ST_OPCODE: if (accept) begin
        if (rom_len == 2'd1) begin
          push       = 1'b1;
          push_entry = '{opcode: byte_i, mnem: rom_mnem, mode: rom_mode,
                         len: rom_len, operand: 16'h0000, illegal: rom_illegal};
        end else begin
          hold_load = 1'b1;
          state_d   = ST_OPER_LO;
        end
      end
      ST_OPER_LO: if (accept) begin
        if (hold_q.len == 2'd2) begin
          push               = 1'b1;
          push_entry         = hold_q;
          push_entry.operand = {8'h00, byte_i};
          state_d            = ST_OPCODE;
        end else begin
          lo_load = 1'b1;
          state_d = ST_OPER_HI;
        end
      end
      ST_OPER_HI: if (accept) begin
        push               = 1'b1;
        push_entry         = hold_q;
        push_entry.operand = {byte_i, hold_q.operand[7:0]};
        state_d            = ST_OPCODE;
      end
      default: state_d = ST_OPCODE;
    endcase
    if (flush_i) state_d = ST_OPCODE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_OPCODE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (hold_load) begin
      hold_q <= '{opcode: byte_i, mnem: rom_mnem, mode: rom_mode,
                  len: rom_len, operand: 16'h0000, illegal: rom_illegal};
    end else if (lo_load) begin
      hold_q.operand[7:0] <= byte_i;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (!push && pop) level_q <= level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trapped_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (flush_i)
        trapped_q <= 1'b0;
      else if (TRAP_EN && push && push_entry.illegal)
        trapped_q <= 1'b1;
      // The count survives flush; it is only cleared by reset.
      if (push && push_entry.illegal && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign head            = (level_q != '0) ? mem[rd_ptr_q] : '0;
  assign insn_valid_o    = (level_q != '0);
  assign insn_opcode_o   = head.opcode;
  assign insn_mnem_o     = head.mnem;
  assign insn_mode_o     = head.mode;
  assign insn_len_o      = head.len;
  assign insn_operand_o  = head.operand;
  assign insn_illegal_o  = head.illegal;
  assign byte_ready_o    = byte_ready;
  assign trapped_o       = trapped_q;
  assign illegal_count_o = cnt_q;
  assign fifo_level_o    = level_q;

endmodule
